// File: rtl/fifo_pkg.sv
// Shared types for the fifo block.
// Names the four possible outcomes of one clock edge.
package fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array with a synchronous write and a combinational read.
// The storage is intentionally not reset.
module fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO with registered read data, a one-cycle data_valid strobe
// and registered full/empty flags derived from the next occupancy.
module fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic             ren,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  logic             rd_ok;
  logic             wr_ok;
  fifo_op_e         op;
  logic [WIDTH-1:0] mem_rdata;

  fifo_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr_q),
    .wdata (data_in),
    .raddr (rptr_q),
    .rdata (mem_rdata)
  );

  // A full FIFO may still take a write when the same edge frees a slot.
  always_comb begin
    rd_ok = ren & ~empty_q;
    wr_ok = wen & (~full_q | rd_ok);
    op    = fifo_op_e'({wr_ok, rd_ok});
  end

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = rd_ok;

    if (wr_ok) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    end
    if (rd_ok) begin
      rptr_d     = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
      data_out_d = mem_rdata;
    end

    case (op)
      OP_WR:   count_d = count_q + 1'b1;
      OP_RD:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign full       = full_q;
  assign empty      = empty_q;

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: stimulus updates a queue-based reference model and
// pushes expected read data; a negedge monitor pops and compares DUT outputs.
module tb_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             wen;
  logic             ren;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             full;
  logic             empty;

  int checks;
  int errors;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_q [$];
  logic             exp_valid;
  logic [WIDTH-1:0] last_out;

  fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen        (wen),
    .ren        (ren),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; applies inputs for the next edge and
  // advances the reference model at that edge.
  task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
    logic rd;
    logic wr;
    wen     = w;
    ren     = r;
    data_in = d;
    @(posedge clk);
    if (rst_n) begin
      rd = r && (model_q.size() > 0);
      wr = w && ((model_q.size() < DEPTH) || rd);
      if (rd) exp_q.push_back(model_q.pop_front());
      if (wr) model_q.push_back(d);
      exp_valid = rd;
      $display("cycle wen=%0d ren=%0d din=%02h rd_ok=%0d wr_ok=%0d occ=%0d",
               w, r, d, rd, wr, model_q.size());
    end else begin
      exp_valid = 1'b0;
    end
    #1;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
  endtask

  // Monitor: every falling edge compares outputs against the model.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      chk("data_valid", {31'b0, data_valid}, {31'b0, exp_valid});
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_read", {31'b0, data_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("read_data", {24'b0, data_out}, {24'b0, e});
          last_out = e;
        end
      end else begin
        chk("data_out_hold", {24'b0, data_out}, {24'b0, last_out});
      end
      chk("full", {31'b0, full}, {31'b0, (model_q.size() == DEPTH)});
      chk("empty", {31'b0, empty}, {31'b0, (model_q.size() == 0)});
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    exp_valid = 1'b0;
    last_out  = '0;
    rst_n     = 1'b0;
    wen       = 1'b0;
    ren       = 1'b0;
    data_in   = '0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single write then read
    cycle(1'b1, 1'b0, 8'hAA);
    idle(5);
    cycle(1'b0, 1'b1, 8'h00);
    idle(2);

    // Fill, overflow attempt, drain
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00);
    idle(2);

    // Underflow
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
    idle(1);

    // Simultaneous while full, then drain
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b1, 1'b1, 8'h09);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00);
    idle(1);

    // Simultaneous while empty
    cycle(1'b1, 1'b1, 8'h5A);
    cycle(1'b0, 1'b1, 8'h00);
    idle(2);

    // Stream with interleaved reads
    for (int i = 0; i < 20; i++) cycle(1'b1, (i >= 3), 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);
    idle(1);

    // Reset mid-stream with 4 entries held
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i));
    rst_n = 1'b0;
    model_q.delete();
    exp_q.delete();
    exp_valid = 1'b0;
    last_out  = '0;
    #1;
    chk("reset_async_empty", {31'b0, empty}, 32'd1);
    chk("reset_async_full", {31'b0, full}, 32'd0);
    chk("reset_async_valid", {31'b0, data_valid}, 32'd0);
    chk("reset_async_dout", {24'b0, data_out}, 32'd0);
    @(posedge clk);
    #1;
    idle(2);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 8'h00);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), 8'($urandom));
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
    idle(3);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock first-in/first-out buffer, DEPTH entries of WIDTH bits.
- Used as a general-purpose elastic buffer between a producer (write side) and a consumer (read side) in the same clock domain.
- Read data is registered, and a one-cycle data_valid strobe qualifies it.

Parameters:
- DEPTH, 8, number of storage entries; integer >= 2, any value (not restricted to powers of two).
- WIDTH, 8, data word width in bits; >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- wen  input  1  write request; data_in is captured on an accepted write.
- ren  input  1  read request; pops the head entry on an accepted read.
- data_in  input  WIDTH  write data.
- data_out  output  WIDTH  registered read data; valid when data_valid=1, otherwise holds its last value.
- data_valid  output  1  high for exactly one cycle after each accepted read.
- full  output  1  high when the occupancy equals DEPTH.
- empty  output  1  high when the occupancy equals 0.

Behaviour:
- State:
  - write pointer and read pointer, each ceil(log2(DEPTH)) bits, wrapping from DEPTH-1 to 0;
  - occupancy counter, ceil(log2(DEPTH+1)) bits;
  - storage array of DEPTH x WIDTH (not reset).
- Reset (rst_n=0, asynchronous): pointers=0, count=0, data_out=0, data_valid=0, full=0, empty=1. Storage contents are undefined after reset.
- Reset mid-operation discards all contents immediately. The first edge after release behaves as from an empty FIFO.
- Accept rules, evaluated on the same edge from the current (pre-edge) state:
  - rd_ok = ren & ~empty;
  - wr_ok = wen & (~full | rd_ok).
- Accepted write:
  - mem[wptr] <= data_in;
  - wptr advances by 1 with wrap.
- Accepted read:
  - data_out <= mem[rptr] on that edge, so the data is visible the cycle after the ren cycle (read latency 1);
  - rptr advances with wrap;
  - data_valid <= 1.
- If no read is accepted: data_valid <= 0 and data_out holds its value.
- Count update:
  - +1 on write only;
  - -1 on read only;
  - unchanged on both or neither.
- full and empty are registered and derived from the next count, so they are valid in the cycle after the edge that changes occupancy.
- Boundary conditions:
  - Write while full, no read: ignored; contents and pointers unchanged, full stays 1.
  - Write and read together while full: both accepted; the oldest entry is output, the new entry is stored, count stays DEPTH.
  - Read while empty: ignored; data_valid=0, data_out unchanged.
  - Write and read together while empty: the write is accepted and the read is ignored (no fall-through bypass); data_valid=0, empty becomes 0.
  - Write and read together at other occupancies: both accepted, count unchanged.
- Ordering: strict FIFO. Wrap-around must preserve order across any number of fill/drain cycles.
- No overflow or underflow error outputs; illegal requests are silently dropped.

Decomposition:
- No shared package is required. Derived widths (pointer and count widths) are localparams inside the module.
- One natural sub-module: fifo_mem, a simple dual-port register array.
  - Write port: we, waddr, wdata.
  - Read port: raddr, rdata, combinational.
  - Pointer, count and flag control stay in fifo.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, then release → empty=1, full=0, data_valid=0, data_out=8'h00.
- Single write/read: wen=1, data_in=8'hAA for one cycle; 5 idle cycles; ren=1 for one cycle → empty drops after the write; the cycle after ren, data_valid=1 and data_out=8'hAA; afterwards data_valid=0 and empty=1.
- Fill and overflow: write 8'h01..8'h08, then attempt 8'hFF → full=1 after the 8th write; 8'hFF dropped; draining yields 8'h01..8'h08 in order, then empty=1.
- Underflow: ren=1 for 3 cycles on an empty FIFO → data_valid stays 0, data_out unchanged, empty stays 1.
- Simultaneous operations:
  - with FIFO full (8'h01..8'h08), wen+ren with data_in=8'h09 → data_out=8'h01, full stays 1, and a later drain yields 8'h02..8'h09;
  - with FIFO empty, wen+ren with data_in=8'h5A → no data_valid, then a read returns 8'h5A.
- Wrap-around and reset mid-stream:
  - stream 20 words (8'h10..8'h23) with interleaved reads keeping occupancy 1–7 → output order matches input exactly;
  - assert rst_n=0 asynchronously with 4 entries held → empty=1 immediately, and the next read after release returns nothing (data_valid=0).
